bg_scroll_fetch: RTL
====================

# bg_scroll_fetch

Scrolling fetch stage between the XVGA display timing generator and the combinational background pixel ROM. Each frame it advances a horizontal scroll offset. It maps raster coordinates to ROM coordinates and registers the returned 12-bit RGB pixel. It delays hsync/vsync/blank to match, so the downstream sprite/wave mixer receives an aligned, scrolled background stream.

## Interface
Parameters:
- WIDTH, 1024: background width in pixels; power of two; ROM x wraps modulo WIDTH.
- HEIGHT, 512: background height in pixels; rows at or beyond HEIGHT show FILL.
- FILL, 12'h000: RGB driven for rows with vcount >= HEIGHT.
- OFS_W, 10: scroll offset width; must equal log2(WIDTH).

Ports:
- clock  in  1  pixel clock (65 MHz domain).
- reset_n  in  1  reset. One clock; reset is synchronous and active-low.
- hcount  in  11  raster x from timing generator.
- vcount  in  10  raster y from timing generator.
- hsync_in, vsync_in  in  1 each  active-low syncs.
- blank_in  in  1  high outside active video.
- speed  in  4  pixels of scroll per frame.
- pause  in  1  hold offset when high.
- rom_x  out  11  x to background ROM (registered).
- rom_y  out  10  y to background ROM (registered).
- rom_pixel  in  12  ROM response (combinational on rom_x/rom_y).
- pixel  out  12  scrolled background RGB.
- hsync_out, vsync_out, blank_out  out  1 each  syncs/blank delayed 2 cycles.
- frame_tick  out  1  one-cycle pulse per frame boundary.

## Operation
- Frame boundary: a registered copy vs_d of vsync_in. Boundary = vs_d==1 and vsync_in==0, i.e. the falling edge.
- At a boundary, speed and pause are sampled. If pause==0: offset <= (offset + speed) mod WIDTH. The add is OFS_W+1 bits wide, then masked. If pause==1, offset holds. speed and pause are ignored between boundaries.
- frame_tick is high for exactly the cycle the new offset is first visible.
- Stage 1 (registered):
  - rom_x <= {0, (hcount + offset) mod WIDTH}.
  - rom_y <= vcount.
  - Sideband registers capture hsync_in, vsync_in, blank_in and oob = (vcount >= HEIGHT).
- Stage 2 (registered):
  - pixel <= 0 if blank_s1; else FILL if oob_s1; else rom_pixel.
  - Syncs and blank advance one more stage.
- Simultaneous boundary and stage-1 capture: stage 1 uses the pre-update offset. The updated offset applies from the next cycle, which falls inside vertical blanking.

## Timing
- Latency hcount/vcount -> rom_x/rom_y is 1 cycle.
- Latency hcount/vcount -> pixel is 2 cycles; syncs and blank_out are also delayed exactly 2 cycles.
- Throughput is one pixel per clock, with no stalls.
- Reset values:
  - rom_x=0, rom_y=0, pixel=0.
  - hsync_out=1, vsync_out=1, blank_out=1.
  - frame_tick=0, offset=0, vs_d=1.
  - Internal sideband registers take the same inactive values.
- Reset mid-frame: all state is cleared on the next edge with reset_n low. Outputs stay at reset values until 2 cycles after reset_n rises. No spurious frame_tick results from the vs_d reset value.
- Wrap-around: offset + speed >= WIDTH wraps; hcount + offset wraps modulo WIDTH. No saturation anywhere.

## Configuration
- BG_SCROLL_EN defined: the offset accumulates as described.
- BG_SCROLL_EN undefined:
  - offset is constant 0, so rom_x = hcount mod WIDTH.
  - speed and pause are ignored.
  - frame_tick and the pipeline behave identically, with the same latency.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with live inputs -> pixel=0, rom_x=0, hsync_out=vsync_out=blank_out=1, frame_tick=0. Release -> first valid pixel 2 cycles later.
- Scroll accumulate: speed=4, three vsync falling edges -> offset=12 and three single-cycle frame_tick pulses. Then hcount=1020 -> rom_x=8 one cycle later.
- Offset wrap: drive offset to 1020, speed=8, one boundary -> offset=4. Then hcount=0 -> rom_x=4.
- Latency/alignment: ROM model returns {hcount[3:0],8'h00}. Step hcount -> pixel and delayed blank/syncs change exactly 2 cycles after the input. blank_in=1 -> pixel=0.
- Out-of-range rows: vcount=600, FILL=12'h0AF, blank_in=0 -> pixel=12'h0AF regardless of rom_pixel.
- Pause and mid-frame changes: pause=1 at a boundary -> offset unchanged and frame_tick still pulses. Changing speed mid-frame does not affect offset until the next boundary.

Source files
------------

// File: rtl/bg_scroll_fetch.sv
// Scrolled background fetch: maps raster x/y to ROM coordinates and realigns
// the returned pixel with delayed syncs/blank. Define BG_SCROLL_EN to enable the per-frame scroll offset.
`timescale 1ns/1ps
module bg_scroll_fetch #(
  parameter int unsigned WIDTH  = 1024,
  parameter int unsigned HEIGHT = 512,
  parameter logic [11:0] FILL   = 12'h000,
  parameter int unsigned OFS_W  = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic [3:0]  speed,
  input  logic        pause,
  output logic [10:0] rom_x,
  output logic [9:0]  rom_y,
  input  logic [11:0] rom_pixel,
  output logic [11:0] pixel,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        frame_tick
);

  localparam logic [10:0]    X_MASK   = 11'(WIDTH - 1);
  localparam logic [OFS_W:0] OFS_MASK = (OFS_W+1)'(WIDTH - 1);

  logic [OFS_W-1:0] offset;
  logic             vs_d;
  logic             armed;
  logic             boundary;
  logic [10:0]      hsum;
  logic             hs_s1, vs_s1, blank_s1, oob_s1;

  // armed masks the first cycle after reset so a low vsync_in there is not
  // mistaken for a falling edge against the vs_d reset value
  assign boundary = armed && vs_d && !vsync_in;
  assign hsum     = hcount + 11'(offset);

`ifdef BG_SCROLL_EN
  logic [OFS_W:0] ofs_sum;
  assign ofs_sum = {1'b0, offset} + (OFS_W+1)'(speed);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      offset <= '0;
    end else if (boundary && !pause) begin
      offset <= OFS_W'(ofs_sum & OFS_MASK);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{speed, pause, OFS_MASK};
  assign offset     = '0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vs_d       <= 1'b1;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
      rom_x      <= '0;
      rom_y      <= '0;
      hs_s1      <= 1'b1;
      vs_s1      <= 1'b1;
      blank_s1   <= 1'b1;
      oob_s1     <= 1'b0;
      pixel      <= '0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      blank_out  <= 1'b1;
    end else begin
      vs_d       <= vsync_in;
      armed      <= 1'b1;
      frame_tick <= boundary;
      // stage 1 sees the pre-update offset on a boundary cycle
      rom_x      <= hsum & X_MASK;
      rom_y      <= vcount;
      hs_s1      <= hsync_in;
      vs_s1      <= vsync_in;
      blank_s1   <= blank_in;
      oob_s1     <= (32'(vcount) >= HEIGHT);
      if (blank_s1) begin
        pixel <= '0;
      end else if (oob_s1) begin
        pixel <= FILL;
      end else begin
        pixel <= rom_pixel;
      end
      hsync_out  <= hs_s1;
      vsync_out  <= vs_s1;
      blank_out  <= blank_s1;
    end
  end

endmodule
